// File: rtl/fourier_input_writer_if.sv
// Sample-source, register-file write and core-control signals of the Fourier input writer.
// master = the writer block, slave = the surrounding source/core environment.
interface fourier_input_writer_if #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              done;
  logic              busy;
  logic [7:0]        frames_done;

  modport master (
    input  in_valid, in_data, abort, done,
    output in_ready, wr_en, wr_addr, wr_data, start, busy, frames_done
  );

  modport slave (
    output in_valid, in_data, abort, done,
    input  in_ready, wr_en, wr_addr, wr_data, start, busy, frames_done
  );
endinterface

// File: rtl/fourier_input_writer.sv
// Loads SIGNAL_COUNT samples into the core register file, pulses start, waits for a done edge.
// Writes land one cycle after accept; in_ready is low outside LOAD so the source is held off.
module fourier_input_writer #(
  parameter int SIGNAL_COUNT = 10,
  parameter int DATA_W       = 17,
  parameter int ADDR_W       = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  fourier_input_writer_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, KICK, WAIT} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIGNAL_COUNT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic [7:0]        frames_done_q, frames_done_d;
  logic              in_ready;
  logic              accept;
  logic              done_rise;

  assign in_ready  = (state_q == LOAD);
  assign accept    = bus.in_valid & in_ready & ~bus.abort;
  assign done_rise = bus.done & ~done_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = bus.done;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    start_d       = 1'b0;
    frames_done_d = frames_done_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (bus.abort) begin
          cnt_d = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = bus.in_data;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = KICK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // The last sample's write is on the bus during this cycle, so start follows it.
      KICK: begin
        start_d = ~bus.abort;
        state_d = bus.abort ? LOAD : WAIT;
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = LOAD;
        end else if (done_rise) begin
          frames_done_d = frames_done_q + 8'd1;
          state_d       = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      start_q       <= 1'b0;
      frames_done_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      start_q       <= start_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.start       = start_q;
  assign bus.frames_done = frames_done_q;
  assign bus.busy        = (state_q == KICK) || (state_q == WAIT) ||
                           ((state_q == LOAD) && (cnt_q != '0));
endmodule

// File: tb/tb_fourier_input_writer.sv
// Bench for fourier_input_writer: randomized source/core stimulus against a frame-level
// reference model (sample queue per frame, expected register-file image per start).
module tb_fourier_input_writer;
  localparam int SC = 10;
  localparam int DW = 17;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fourier_input_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fourier_input_writer #(.SIGNAL_COUNT(SC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: where the frame stands and which samples it holds.
  bit            m_boot, m_load, m_kick, m_wait, m_prev_done, m_took;
  logic [DW-1:0] m_frame[$];
  logic [DW-1:0] m_last[SC];
  logic [DW-1:0] mem[SC];
  int            m_frames_total;
  bit            e_wr_en, e_start;
  int            e_wr_addr;
  logic [DW-1:0] e_wr_data;

  // Stimulus knobs and core emulation.
  int            k_vpct, k_every, k_apct, core_mode, abort_at_n;
  bit            k_seq, abort_kick;
  int            cyc, core_wait, core_hold;
  logic [DW-1:0] seq_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_load = 1'b0; m_kick = 1'b0; m_wait = 1'b0;
    m_prev_done = 1'b0; m_took = 1'b0;
    m_frame.delete();
    m_frames_total = 0;
    e_wr_en = 1'b0; e_start = 1'b0; e_wr_addr = 0; e_wr_data = '0;
    core_wait = 0; core_hold = 0;
  endtask

  // Apply the rules for one clock edge to the inputs currently driven.
  task automatic model_edge();
    bit v, ab, dn;
    v  = bus.in_valid;
    ab = bus.abort;
    dn = bus.done;
    e_wr_en = 1'b0;
    e_start = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      m_load = 1'b1;
    end else if (m_load) begin
      if (v) m_took = 1'b1;
      if (ab) begin
        m_frame.delete();
      end else if (v) begin
        e_wr_en   = 1'b1;
        e_wr_addr = m_frame.size();
        e_wr_data = bus.in_data;
        m_frame.push_back(bus.in_data);
        if (m_frame.size() == SC) begin
          for (int i = 0; i < SC; i++) m_last[i] = m_frame[i];
          m_frame.delete();
          m_load = 1'b0;
          m_kick = 1'b1;
        end
      end
    end else if (m_kick) begin
      m_kick = 1'b0;
      if (ab) m_load = 1'b1;
      else begin
        e_start = 1'b1;
        m_wait  = 1'b1;
      end
    end else if (m_wait) begin
      if (ab) begin
        m_wait = 1'b0; m_load = 1'b1;
      end else if (dn && !m_prev_done) begin
        m_wait = 1'b0; m_load = 1'b1;
        m_frames_total++;
      end
    end
    m_prev_done = dn;
  endtask

  task automatic compare_all();
    bit exp_busy;
    if (bus.wr_en === 1'b1 && int'(bus.wr_addr) < SC) mem[bus.wr_addr] = bus.wr_data;
    exp_busy = m_kick || m_wait || (m_load && m_frame.size() != 0);
    check_eq("in_ready",    32'(bus.in_ready),    32'(m_load));
    check_eq("wr_en",       32'(bus.wr_en),       32'(e_wr_en));
    check_eq("wr_addr",     32'(bus.wr_addr),     32'(e_wr_addr));
    check_eq("wr_data",     32'(bus.wr_data),     32'(e_wr_data));
    check_eq("start",       32'(bus.start),       32'(e_start));
    check_eq("busy",        32'(bus.busy),        32'(exp_busy));
    check_eq("frames_done", 32'(bus.frames_done), 32'(m_frames_total % 256));
    if (e_start)
      for (int i = 0; i < SC; i++) check_eq("frame_image", 32'(mem[i]), 32'(m_last[i]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive();
    bit v, ab;
    cyc++;
    if (!bus.in_valid || m_took) begin
      m_took = 1'b0;
      if (k_every > 0) v = (cyc % k_every) == 0;
      else             v = $urandom_range(99) < k_vpct;
      bus.in_valid = v;
      if (v) begin
        if (k_seq) begin
          bus.in_data = seq_val;
          seq_val++;
        end else begin
          bus.in_data = DW'($urandom);
        end
      end
    end
    ab = $urandom_range(99) < k_apct;
    if (abort_at_n >= 0 && m_load && bus.in_valid && m_frame.size() == abort_at_n) begin
      ab = 1'b1;
      abort_at_n = -1;
    end
    if (abort_kick && m_kick) begin
      ab = 1'b1;
      abort_kick = 1'b0;
    end
    bus.abort = ab;
    // Core emulation: mode 0 answers each start with a short done pulse, mode 1 toggles freely.
    if (core_mode == 0) begin
      if (e_start) begin
        core_wait = $urandom_range(1, 5);
      end else if (core_wait > 0) begin
        core_wait--;
        if (core_wait == 0) begin
          bus.done  = 1'b1;
          core_hold = $urandom_range(1, 3);
        end
      end else if (bus.done && core_hold > 0) begin
        core_hold--;
        if (core_hold == 0) bus.done = 1'b0;
      end
    end else if (core_mode == 1) begin
      if ($urandom_range(99) < 15) bus.done = ~bus.done;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic run_frames(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_frames_total < target && n < budget) begin
      drive();
      step();
      n++;
    end
    check_eq(tag, 32'(m_frames_total >= target), 32'd1);
  endtask

  task automatic reset_dut();
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    bus.done     = 1'b0;
    #1;
    check_eq("rst_in_ready",    32'(bus.in_ready),    32'd0);
    check_eq("rst_wr_en",       32'(bus.wr_en),       32'd0);
    check_eq("rst_wr_addr",     32'(bus.wr_addr),     32'd0);
    check_eq("rst_wr_data",     32'(bus.wr_data),     32'd0);
    check_eq("rst_start",       32'(bus.start),       32'd0);
    check_eq("rst_busy",        32'(bus.busy),        32'd0);
    check_eq("rst_frames_done", 32'(bus.frames_done), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.abort    = 1'b0;
    bus.done     = 1'b0;
    cyc = 0; abort_at_n = -1; abort_kick = 1'b0;
    k_vpct = 100; k_every = 0; k_apct = 0; k_seq = 1'b1; seq_val = DW'(1);
    core_mode = 2;
    for (int i = 0; i < SC; i++) mem[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset_dut();

    // Back-to-back samples 1..10 with done already high: that level must not count.
    bus.done = 1'b1;
    run_cycles(32);
    bus.done = 1'b0;
    run_cycles(20);
    bus.done = 1'b1;
    run_cycles(1);
    check_eq("first_done_edge", 32'(bus.frames_done), 32'd1);
    run_cycles(1);

    // Sparse source, one sample every third cycle.
    bus.done = 1'b0; core_mode = 0; k_seq = 1'b0; k_every = 3;
    run_frames(m_frames_total + 1, 300, "sparse_timeout");

    // Abort coinciding with the fifth sample.
    k_every = 0; abort_at_n = 4;
    run_frames(m_frames_total + 1, 200, "abort4_timeout");
    check_eq("abort4_fired", 32'(abort_at_n), 32'hFFFF_FFFF);

    // Abort in the cycle the last sample is being written.
    abort_kick = 1'b1;
    n = 0;
    while (abort_kick && n < 100) begin
      drive();
      step();
      n++;
    end
    check_eq("abort_kick_fired", 32'(abort_kick), 32'd0);
    run_cycles(30);

    // Random mix: sparse valid, occasional aborts, done toggling at arbitrary times.
    k_vpct = 70; k_apct = 3; core_mode = 1;
    run_cycles(1500);
    bus.done = 1'b0; core_mode = 0; k_apct = 2;
    run_cycles(800);

    // 257 frames from reset wrap the frame counter to 1, then reset mid-frame.
    k_vpct = 100; k_apct = 0;
    reset_dut();
    run_frames(257, 20000, "wrap_timeout");
    check_eq("frames_wrap", 32'(bus.frames_done), 32'd1);
    n = 0;
    while (!(m_load && m_frame.size() == 5) && n < 60) begin
      drive();
      step();
      n++;
    end
    check_eq("midframe_reached", 32'(m_frame.size()), 32'd5);
    reset_dut();
    k_vpct = 60;
    run_cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
